// File: rtl/unified_cache_mem_responder.sv
// ---------------------------------------------------------------------------
// unified_cache_mem_responder
//
// Memory-side responder for the unified cache's memory port. It accepts one
// request packet at a time, waits a fixed number of cycles, and then:
//   - for a write, merges the packet data into the block array under the
//     byte mask;
//   - for a read, returns the whole block in a packet and holds that packet
//     until the cache acknowledges it.
//
// Ports
//   clk_in                     clock
//   reset_in                   synchronous, active-low reset
//   from_cache_packet_in       request packet from the cache
//   from_cache_packet_ack_out  one-cycle pulse in the cycle after acceptance
//   to_cache_packet_out        read return packet (all zero when idle)
//   to_cache_packet_ack_in     cache has consumed the read return
//   busy_out                   high whenever the FSM is not idle
//   read_count_out             reads completed (return acknowledged)
//   write_count_out            writes completed
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES        32
`define UNIFIED_CACHE_PACKET_DATA_POS_LO         0
`define UNIFIED_CACHE_PACKET_DATA_POS_HI         255
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO         256
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI         287
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO    288
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI    319
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO     320
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI     321
`define UNIFIED_CACHE_PACKET_TYPE_POS_LO         322
`define UNIFIED_CACHE_PACKET_TYPE_POS_HI         323
`define UNIFIED_CACHE_PACKET_CACHEABLE_POS       324
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS        325
`define UNIFIED_CACHE_PACKET_VALID_POS           326
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS       327
`endif

module unified_cache_mem_responder #(
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int BLOCK_SIZE_IN_BYTES                = `UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES,
  parameter int MEM_DEPTH                          = 64,
  parameter int MEM_DELAY                          = 100
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] from_cache_packet_in,
  output logic                                          from_cache_packet_ack_out,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] to_cache_packet_out,
  input  logic                                          to_cache_packet_ack_in,
  output logic                                          busy_out,
  output logic [31:0]                                   read_count_out,
  output logic [31:0]                                   write_count_out
);

  localparam int PW          = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int BLOCK_BITS  = 8 * BLOCK_SIZE_IN_BYTES;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE_IN_BYTES);
  localparam int IDX_BITS    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W       = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_DELAY > 0) ? MEM_DELAY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DELAY       = 2'd1,
    WRITE       = 2'd2,
    READ_RETURN = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           req_q, req_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic [PW-1:0]           out_q, out_d;
  logic [31:0]             rd_cnt_q, rd_cnt_d;
  logic [31:0]             wr_cnt_q, wr_cnt_d;
  logic [BLOCK_BITS-1:0]   rd_blk_q;
  logic [BLOCK_BITS-1:0]   mem [MEM_DEPTH];
  logic [IDX_BITS-1:0]     wr_idx, rd_idx;

  // Address bits above the block offset select the block; upper bits beyond
  // the array depth are dropped, so addresses wrap modulo MEM_DEPTH.
  assign wr_idx = req_q[`UNIFIED_CACHE_PACKET_ADDR_POS_LO + OFFSET_BITS +: IDX_BITS];
  // The read port follows the request about to be latched, so the block is
  // already sitting in rd_blk_q even when a read goes straight to
  // READ_RETURN with zero delay.
  assign rd_idx = req_d[`UNIFIED_CACHE_PACKET_ADDR_POS_LO + OFFSET_BITS +: IDX_BITS];

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    out_d    = out_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      IDLE: begin
        if (from_cache_packet_in[`UNIFIED_CACHE_PACKET_VALID_POS]) begin
          req_d = from_cache_packet_in;
          ack_d = 1'b1;
          cnt_d = '0;
          if (MEM_DELAY > 0) begin
            state_d = DELAY;
          end else if (from_cache_packet_in[`UNIFIED_CACHE_PACKET_IS_WRITE_POS]) begin
            state_d = WRITE;
          end else begin
            state_d = READ_RETURN;
          end
        end
      end
      DELAY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = req_q[`UNIFIED_CACHE_PACKET_IS_WRITE_POS] ? WRITE : READ_RETURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        wr_cnt_d = wr_cnt_q + 32'd1;
        state_d  = IDLE;
      end
      READ_RETURN: begin
        // First cycle here builds the return; afterwards it is held until acked.
        if (!out_q[`UNIFIED_CACHE_PACKET_VALID_POS]) begin
          out_d = '0;
          out_d[`UNIFIED_CACHE_PACKET_DATA_POS_HI:`UNIFIED_CACHE_PACKET_DATA_POS_LO] = rd_blk_q;
          out_d[`UNIFIED_CACHE_PACKET_ADDR_POS_HI:`UNIFIED_CACHE_PACKET_ADDR_POS_LO] =
            req_q[`UNIFIED_CACHE_PACKET_ADDR_POS_HI:`UNIFIED_CACHE_PACKET_ADDR_POS_LO];
          out_d[`UNIFIED_CACHE_PACKET_TYPE_POS_HI:`UNIFIED_CACHE_PACKET_TYPE_POS_LO] =
            req_q[`UNIFIED_CACHE_PACKET_TYPE_POS_HI:`UNIFIED_CACHE_PACKET_TYPE_POS_LO];
          out_d[`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI:`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO] =
            req_q[`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI:`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO];
          out_d[`UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI:`UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO] =
            req_q[`UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI:`UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO];
          out_d[`UNIFIED_CACHE_PACKET_CACHEABLE_POS] = req_q[`UNIFIED_CACHE_PACKET_CACHEABLE_POS];
          out_d[`UNIFIED_CACHE_PACKET_IS_WRITE_POS]  = 1'b0;
          // A request is only ever latched with VALID set, so this is always 1.
          out_d[`UNIFIED_CACHE_PACKET_VALID_POS]     = req_q[`UNIFIED_CACHE_PACKET_VALID_POS];
        end else if (to_cache_packet_ack_in) begin
          out_d    = '0;
          rd_cnt_d = rd_cnt_q + 32'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      out_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      out_q    <= out_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Block array: byte-enable write, registered read. Not reset; a write
  // whose edge coincides with reset is dropped with the rest of the request.
  always_ff @(posedge clk_in) begin
    if (reset_in && state_q == WRITE) begin
      for (int b = 0; b < BLOCK_SIZE_IN_BYTES; b++) begin
        if (req_q[`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO + b]) begin
          mem[wr_idx][8*b +: 8] <= req_q[`UNIFIED_CACHE_PACKET_DATA_POS_LO + 8*b +: 8];
        end
      end
    end
    rd_blk_q <= mem[rd_idx];
  end

  assign from_cache_packet_ack_out = ack_q;
  assign to_cache_packet_out       = out_q;
  assign busy_out                  = (state_q != IDLE);
  assign read_count_out            = rd_cnt_q;
  assign write_count_out           = wr_cnt_q;

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
`timescale 1ns/1ps

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES        32
`define UNIFIED_CACHE_PACKET_DATA_POS_LO         0
`define UNIFIED_CACHE_PACKET_DATA_POS_HI         255
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO         256
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI         287
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO    288
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI    319
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO     320
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI     321
`define UNIFIED_CACHE_PACKET_TYPE_POS_LO         322
`define UNIFIED_CACHE_PACKET_TYPE_POS_HI         323
`define UNIFIED_CACHE_PACKET_CACHEABLE_POS       324
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS        325
`define UNIFIED_CACHE_PACKET_VALID_POS           326
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS       327
`endif

// Two responders side by side: instance 0 with a 4-cycle access delay,
// instance 1 with zero delay. Both have 64 blocks of 32 bytes.
module tb_unified_cache_mem_responder;

  localparam int PW    = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int NB    = `UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES;
  localparam int BB    = 8 * NB;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   [2];
  logic [PW-1:0] req_pkt [2];
  logic          req_ack [2];
  logic [PW-1:0] ret_pkt [2];
  logic          ret_ack [2];
  logic          busy    [2];
  logic [31:0]   rd_cnt  [2];
  logic [31:0]   wr_cnt  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    unified_cache_mem_responder #(
      .MEM_DEPTH (DEPTH),
      .MEM_DELAY ((gi == 0) ? 4 : 0)
    ) u_dut (
      .clk_in                    (clk),
      .reset_in                  (rst_n[gi]),
      .from_cache_packet_in      (req_pkt[gi]),
      .from_cache_packet_ack_out (req_ack[gi]),
      .to_cache_packet_out       (ret_pkt[gi]),
      .to_cache_packet_ack_in    (ret_ack[gi]),
      .busy_out                  (busy[gi]),
      .read_count_out            (rd_cnt[gi]),
      .write_count_out           (wr_cnt[gi])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain block contents and completion counts.
  logic [BB-1:0] mdl_mem [2][DEPTH];
  int            rd_exp  [2];
  int            wr_exp  [2];
  logic [PW-1:0] sb [$];

  function automatic int delay_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor: pops the scoreboard on each new return --------
  logic          mon_prev_ack [2];
  logic          mon_prev_vld [2];
  logic [PW-1:0] mon_prev_pkt [2];
  int            mon_ack_cyc  [2];
  logic [PW-1:0] mon_exp;
  int            mon_lat;

  initial begin
    for (int k = 0; k < 2; k++) begin
      mon_prev_ack[k] = 1'b0;
      mon_prev_vld[k] = 1'b0;
      mon_prev_pkt[k] = '0;
      mon_ack_cyc[k]  = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n[k] === 1'b1) begin
        if (req_ack[k] === 1'b1) begin
          n_cmp++;
          if (mon_prev_ack[k] === 1'b1) begin
            n_bad++;
            $display("FAIL ack_width inst%0d: ack high two cycles running, expected a single-cycle pulse", k);
          end
          mon_ack_cyc[k] = cyc;
        end
        if (ret_pkt[k][`UNIFIED_CACHE_PACKET_VALID_POS] === 1'b1 && mon_prev_vld[k] !== 1'b1) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_return inst%0d: got %h, expected no return", k, ret_pkt[k]);
          end else begin
            mon_exp = sb.pop_front();
            if (ret_pkt[k] !== mon_exp) begin
              n_bad++;
              $display("FAIL return_pkt inst%0d: got %h, expected %h", k, ret_pkt[k], mon_exp);
            end
          end
          mon_lat = cyc - mon_ack_cyc[k];
          chk($sformatf("return_latency_inst%0d", k), 64'(mon_lat), 64'(delay_of(k) + 1));
        end else if (ret_pkt[k][`UNIFIED_CACHE_PACKET_VALID_POS] === 1'b1) begin
          n_cmp++;
          if (ret_pkt[k] !== mon_prev_pkt[k]) begin
            n_bad++;
            $display("FAIL return_stable inst%0d: got %h, expected %h", k, ret_pkt[k], mon_prev_pkt[k]);
          end
        end
      end
      mon_prev_ack[k] = req_ack[k];
      mon_prev_vld[k] = ret_pkt[k][`UNIFIED_CACHE_PACKET_VALID_POS];
      mon_prev_pkt[k] = ret_pkt[k];
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  function automatic logic [BB-1:0] rand_block();
    logic [BB-1:0] v;
    for (int w = 0; w < BB / 32; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [PW-1:0] make_req(input bit wr, input logic [31:0] addr,
                                             input logic [BB-1:0] data, input logic [NB-1:0] mask);
    logic [PW-1:0] p;
    p = '0;
    p[`UNIFIED_CACHE_PACKET_VALID_POS]     = 1'b1;
    p[`UNIFIED_CACHE_PACKET_IS_WRITE_POS]  = wr;
    p[`UNIFIED_CACHE_PACKET_CACHEABLE_POS] = 1'($urandom);
    p[`UNIFIED_CACHE_PACKET_ADDR_POS_HI:`UNIFIED_CACHE_PACKET_ADDR_POS_LO]         = addr;
    p[`UNIFIED_CACHE_PACKET_DATA_POS_HI:`UNIFIED_CACHE_PACKET_DATA_POS_LO]         = data;
    p[`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI:`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO] = mask;
    p[`UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI:`UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO] = 2'($urandom);
    p[`UNIFIED_CACHE_PACKET_TYPE_POS_HI:`UNIFIED_CACHE_PACKET_TYPE_POS_LO]         = 2'($urandom);
    return p;
  endfunction

  // Present a request and wait for its acceptance pulse.
  task automatic issue(input int k, input logic [PW-1:0] p);
    int t;
    @(negedge clk);
    req_pkt[k] = p;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (req_ack[k] !== 1'b1 && t < 200);
    chk($sformatf("accept_ack_inst%0d", k), 64'(req_ack[k]), 64'd1);
    req_pkt[k] = '0;
  endtask

  task automatic do_op(input int k, input bit wr, input logic [31:0] addr,
                       input logic [BB-1:0] data, input logic [NB-1:0] mask, input int hold);
    logic [PW-1:0] p;
    logic [PW-1:0] e;
    int            idx;
    int            t;
    p   = make_req(wr, addr, data, mask);
    idx = int'((addr / NB) % DEPTH);
    $display("op inst%0d %s addr=%08h idx=%0d mask=%08h hold=%0d", k, wr ? "WR" : "RD", addr, idx, mask, hold);
    if (!wr) begin
      e = '0;
      e[`UNIFIED_CACHE_PACKET_VALID_POS]     = 1'b1;
      e[`UNIFIED_CACHE_PACKET_CACHEABLE_POS] = p[`UNIFIED_CACHE_PACKET_CACHEABLE_POS];
      e[`UNIFIED_CACHE_PACKET_ADDR_POS_HI:`UNIFIED_CACHE_PACKET_ADDR_POS_LO]           = addr;
      e[`UNIFIED_CACHE_PACKET_DATA_POS_HI:`UNIFIED_CACHE_PACKET_DATA_POS_LO]           = mdl_mem[k][idx];
      e[`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI:`UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO] = mask;
      e[`UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI:`UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO] =
        p[`UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI:`UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO];
      e[`UNIFIED_CACHE_PACKET_TYPE_POS_HI:`UNIFIED_CACHE_PACKET_TYPE_POS_LO] =
        p[`UNIFIED_CACHE_PACKET_TYPE_POS_HI:`UNIFIED_CACHE_PACKET_TYPE_POS_LO];
      sb.push_back(e);
    end
    issue(k, p);
    if (wr) begin
      for (int b = 0; b < NB; b++)
        if (mask[b]) mdl_mem[k][idx][8*b +: 8] = data[8*b +: 8];
      wr_exp[k]++;
      t = 0;
      while (busy[k] !== 1'b0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("write_done_idle_inst%0d", k), 64'(busy[k]), 64'd0);
      chk($sformatf("write_count_inst%0d", k), 64'(wr_cnt[k]), 64'(wr_exp[k]));
    end else begin
      t = 0;
      while (ret_pkt[k][`UNIFIED_CACHE_PACKET_VALID_POS] !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("read_valid_inst%0d", k), 64'(ret_pkt[k][`UNIFIED_CACHE_PACKET_VALID_POS]), 64'd1);
      // While the return is held, offer another request: it must not be taken.
      for (int h = 0; h < hold; h++) begin
        if (h == 0) req_pkt[k] = make_req(1'b1, $urandom, rand_block(), '1);
        @(negedge clk);
        chk($sformatf("held_no_ack_inst%0d", k), 64'(req_ack[k]), 64'd0);
        chk($sformatf("held_busy_inst%0d", k), 64'(busy[k]), 64'd1);
      end
      req_pkt[k] = '0;
      ret_ack[k] = 1'b1;
      @(negedge clk);
      ret_ack[k] = 1'b0;
      rd_exp[k]++;
      chk($sformatf("return_cleared_inst%0d", k), 64'(|ret_pkt[k]), 64'd0);
      chk($sformatf("read_count_inst%0d", k), 64'(rd_cnt[k]), 64'(rd_exp[k]));
      chk($sformatf("read_done_idle_inst%0d", k), 64'(busy[k]), 64'd0);
    end
  endtask

  // ---------------- main sequence -----------------------------------------
  logic [BB-1:0] pat_a;
  logic [PW-1:0] pr;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k]   = 1'b0;
      req_pkt[k] = make_req(1'b1, 32'h40, '1, '1);
      ret_ack[k] = 1'b0;
      rd_exp[k]  = 0;
      wr_exp[k]  = 0;
    end

    // Reset held with a valid request on the input: nothing may happen.
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("reset_no_ack_inst%0d", k), 64'(req_ack[k]), 64'd0);
        chk($sformatf("reset_busy_inst%0d", k), 64'(busy[k]), 64'd0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_return_inst%0d", k), 64'(|ret_pkt[k]), 64'd0);
      chk($sformatf("reset_rd_count_inst%0d", k), 64'(rd_cnt[k]), 64'd0);
      chk($sformatf("reset_wr_count_inst%0d", k), 64'(wr_cnt[k]), 64'd0);
      req_pkt[k] = '0;
      rst_n[k]   = 1'b1;
    end

    // Preload every block; upper address bits are random to exercise wrap.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++)
        do_op(k, 1'b1, {$urandom_range(0, 1023), 6'(i), 5'($urandom)}, rand_block(), '1, 0);

    // Write then read block 2, full mask.
    pat_a = rand_block();
    do_op(0, 1'b1, 32'h40, pat_a, '1, 0);
    do_op(0, 1'b0, 32'h40, '0, '1, 0);

    // Partial write over an all-ones block.
    do_op(0, 1'b1, 32'h60, '1, '1, 0);
    do_op(0, 1'b1, 32'h60, '0, 32'h0000_000F, 0);
    do_op(0, 1'b0, 32'h60, '0, '1, 0);

    // All-zero mask leaves the block unchanged.
    do_op(0, 1'b1, 32'h60, rand_block(), '0, 0);
    do_op(0, 1'b0, 32'h60, '0, '1, 0);

    // Backpressure: return held for 20 cycles.
    do_op(0, 1'b0, $urandom, '0, 32'($urandom), 20);

    // Zero delay with address wrap onto the same block as 0x20.
    do_op(1, 1'b1, 64 * 32 + 32'h20, rand_block(), '1, 0);
    do_op(1, 1'b0, 32'h20, '0, '1, 0);
    do_op(1, 1'b0, $urandom, '0, '1, 5);

    // Reset during the delay of a write: the write is lost.
    pr = make_req(1'b1, 32'h0000_00A0, rand_block(), '1);
    $display("op inst0 WR addr=000000a0 idx=5 interrupted by reset");
    issue(0, pr);
    @(negedge clk);
    rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_busy_inst0", 64'(busy[0]), 64'd0);
    rst_n[0] = 1'b1;
    rd_exp[0] = 0;
    wr_exp[0] = 0;
    chk("midreset_wr_count_inst0", 64'(wr_cnt[0]), 64'd0);
    repeat (6) @(negedge clk);
    chk("midreset_wr_count_later_inst0", 64'(wr_cnt[0]), 64'd0);
    do_op(0, 1'b0, 32'h0000_00A0, '0, '1, 0);

    // Randomized mix on both instances.
    for (int n = 0; n < 80; n++) begin
      automatic int k = n % 2;
      do_op(k, 1'($urandom), $urandom, rand_block(), 32'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
